// File: rtl/hamming_pkg.sv
// Shared definitions for the (12,8) Hamming codec: field layout, parity masks,
// syndrome-to-position map and the matching encoder.
package hamming_pkg;

    localparam int CW_W   = 12;
    localparam int DATA_W = 8;
    localparam int SYN_W  = 4;
    localparam int PAR_W  = CW_W - DATA_W;

    localparam int DATA_LSB = 0;
    localparam int PAR_LSB  = DATA_W;

    // Data bits covered by each parity bit p0..p3
    localparam logic [DATA_W-1:0] P0_MASK = 8'h5B;
    localparam logic [DATA_W-1:0] P1_MASK = 8'h6D;
    localparam logic [DATA_W-1:0] P2_MASK = 8'h8E;
    localparam logic [DATA_W-1:0] P3_MASK = 8'hF0;

    typedef logic [CW_W-1:0]   cw_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [SYN_W-1:0]  syn_t;

    typedef struct packed {
        logic       hit;
        logic [3:0] idx;
    } pos_t;

    function automatic pos_t syn_to_pos(input syn_t syn);
        pos_t p;
        p.hit = 1'b1;
        p.idx = 4'd0;
        case (syn)
            4'd1:    p.idx = 4'd8;
            4'd2:    p.idx = 4'd9;
            4'd4:    p.idx = 4'd10;
            4'd8:    p.idx = 4'd11;
            4'd3:    p.idx = 4'd0;
            4'd5:    p.idx = 4'd1;
            4'd6:    p.idx = 4'd2;
            4'd7:    p.idx = 4'd3;
            4'd9:    p.idx = 4'd4;
            4'd10:   p.idx = 4'd5;
            4'd11:   p.idx = 4'd6;
            4'd12:   p.idx = 4'd7;
            default: p.hit = 1'b0;
        endcase
        return p;
    endfunction

    function automatic cw_t hamming_encode(input data_t d);
        logic [PAR_W-1:0] p;
        p[0] = ^(d & P0_MASK);
        p[1] = ^(d & P1_MASK);
        p[2] = ^(d & P2_MASK);
        p[3] = ^(d & P3_MASK);
        return {p, d};
    endfunction

endpackage

// File: rtl/hamming_stream_decoder_syndrome.sv
// Combinational syndrome of a 12-bit codeword against the encoder parity masks.
module hamming_syndrome
    import hamming_pkg::*;
(
    input  logic [CW_W-1:0]  codeword,
    output logic [SYN_W-1:0] syndrome
);

    logic [DATA_W-1:0] data;
    logic [PAR_W-1:0]  par;

    assign data = codeword[PAR_LSB-1:DATA_LSB];
    assign par  = codeword[CW_W-1:PAR_LSB];

    assign syndrome[0] = par[0] ^ (^(data & P0_MASK));
    assign syndrome[1] = par[1] ^ (^(data & P1_MASK));
    assign syndrome[2] = par[2] ^ (^(data & P2_MASK));
    assign syndrome[3] = par[3] ^ (^(data & P3_MASK));

endmodule

// File: rtl/hamming_stream_decoder.sv
// Two-stage valid/ready Hamming (12,8) decoder with single-bit correction
// and saturating corrected/uncorrectable word counters.
module hamming_stream_decoder
    import hamming_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [11:0]      in_codeword,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic [3:0]       out_syndrome,
    output logic             out_err_detected,
    output logic             out_err_corrected,
    output logic             out_uncorrectable,
    input  logic             clear_counts,
    output logic [CNT_W-1:0] corrected_count,
    output logic [CNT_W-1:0] uncorr_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic       s1_valid_q, s1_valid_d;
    cw_t        s1_cw_q, s1_cw_d;
    syn_t       s1_syn_q, s1_syn_d;

    logic       s2_valid_q, s2_valid_d;
    data_t      s2_data_q, s2_data_d;
    syn_t       s2_syn_q, s2_syn_d;
    logic       s2_det_q, s2_det_d;
    logic       s2_cor_q, s2_cor_d;
    logic       s2_unc_q, s2_unc_d;

    logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
    logic [CNT_W-1:0] unc_cnt_q, unc_cnt_d;

    syn_t       in_syn;
    pos_t       pos;
    cw_t        fixed_cw;
    logic       s2_can_load;
    logic       s2_load;
    logic       in_fire;
    logic       out_fire;

    hamming_syndrome u_syndrome (
        .codeword (in_codeword),
        .syndrome (in_syn)
    );

    assign s2_can_load = !s2_valid_q || out_ready;
    assign s2_load     = s1_valid_q && s2_can_load;
    assign in_ready    = !rst && (!s1_valid_q || s2_can_load);
    assign in_fire     = in_valid && in_ready;
    assign out_fire    = s2_valid_q && out_ready;

    assign pos      = syn_to_pos(s1_syn_q);
    assign fixed_cw = pos.hit ? (s1_cw_q ^ (cw_t'(1) << pos.idx)) : s1_cw_q;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_cw_d    = s1_cw_q;
        s1_syn_d   = s1_syn_q;
        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_cw_d    = in_codeword;
            s1_syn_d   = in_syn;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_syn_d   = s2_syn_q;
        s2_det_d   = s2_det_q;
        s2_cor_d   = s2_cor_q;
        s2_unc_d   = s2_unc_q;
        if (s2_load) begin
            s2_valid_d = 1'b1;
            s2_data_d  = fixed_cw[PAR_LSB-1:DATA_LSB];
            s2_syn_d   = s1_syn_q;
            s2_det_d   = |s1_syn_q;
            s2_cor_d   = pos.hit;
            s2_unc_d   = (|s1_syn_q) && !pos.hit;
        end else if (out_fire) begin
            s2_valid_d = 1'b0;
        end
    end

    // Clear takes priority over a coincident delivered-word increment
    always_comb begin
        corr_cnt_d = corr_cnt_q;
        unc_cnt_d  = unc_cnt_q;
        if (clear_counts) begin
            corr_cnt_d = '0;
            unc_cnt_d  = '0;
        end else if (out_fire) begin
            if (s2_cor_q && corr_cnt_q != CNT_MAX) corr_cnt_d = corr_cnt_q + 1'b1;
            if (s2_unc_q && unc_cnt_q != CNT_MAX)  unc_cnt_d  = unc_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_cw_q    <= '0;
            s1_syn_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_syn_q   <= '0;
            s2_det_q   <= 1'b0;
            s2_cor_q   <= 1'b0;
            s2_unc_q   <= 1'b0;
            corr_cnt_q <= '0;
            unc_cnt_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_cw_q    <= s1_cw_d;
            s1_syn_q   <= s1_syn_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_syn_q   <= s2_syn_d;
            s2_det_q   <= s2_det_d;
            s2_cor_q   <= s2_cor_d;
            s2_unc_q   <= s2_unc_d;
            corr_cnt_q <= corr_cnt_d;
            unc_cnt_q  <= unc_cnt_d;
        end
    end

    assign out_valid         = s2_valid_q;
    assign out_data          = s2_data_q;
    assign out_syndrome      = s2_syn_q;
    assign out_err_detected  = s2_det_q;
    assign out_err_corrected = s2_cor_q;
    assign out_uncorrectable = s2_unc_q;
    assign corrected_count   = corr_cnt_q;
    assign uncorr_count      = unc_cnt_q;

endmodule
